// File: rtl/memfifo_re_pkg.sv
// Shared types and helpers for the multi-channel MEMFIFO read-enable sequencer.
package memfifo_re_pkg;

  localparam int unsigned MAX_CH          = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned DEF_EXTRA_DELAY = 11;
  localparam int unsigned DEF_GAP_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_READ,
    S_GAP,
    S_DONE
  } state_t;

  // First requesting channel at or after ptr, wrapping within nch channels.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                               input logic [IDX_W-1:0]  ptr,
                                               input int unsigned       nch);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (k < nch) begin
        idx = 32'(ptr) + k;
        if (idx >= nch) idx = idx - nch;
        if (!found && req[idx[IDX_W-1:0]]) begin
          pick  = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_after(input logic [IDX_W-1:0] idx,
                                                input int unsigned      nch);
    return (32'(idx) + 1 >= nch) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/memfifo_re_sequencer_arb.sv
// Round-robin arbiter: request vector plus start pointer -> one-hot grant and next pointer.
module rr_arbiter_nch
  import memfifo_re_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] next_ptr,
  output logic             any_req
);

  logic [MAX_CH-1:0] req_pad;
  logic [IDX_W-1:0]  grant_idx;

  always_comb begin
    req_pad = '0;
    for (int unsigned i = 0; i < NCH; i++) req_pad[i] = req[i];
    grant_idx = rr_pick(req_pad, ptr, NCH);
    any_req   = |req;
    grant     = '0;
    for (int unsigned i = 0; i < NCH; i++)
      grant[i] = any_req && (grant_idx == IDX_W'(i));
    next_ptr = rr_after(grant_idx, NCH);
  end

endmodule

// File: rtl/memfifo_re_sequencer.sv
// Multi-channel MEMFIFO read-enable sequencer emulating TOP_SERDES readout.
// Optional `abort` input enabled by defining MEMFIFO_RE_ABORT_EN.
module memfifo_re_sequencer
  import memfifo_re_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned PKT_W       = 16,
  parameter int unsigned EXTRA_DELAY = DEF_EXTRA_DELAY,
  parameter int unsigned GAP_W       = DEF_GAP_W
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MEMFIFO_RE_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic                 enable,
  input  logic [NCH*PKT_W-1:0] packet_no,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [GAP_W-1:0]     gap_cfg,
  output logic [NCH-1:0]       memfifo_re,
  output logic                 last_memfifo_re,
  output logic                 busy
);

  localparam logic [7:0] DELAY_INIT = 8'(EXTRA_DELAY);

  state_t           state;
  logic             start_q, enable_q, start_pending;
  logic [7:0]       dly_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] ptr, next_ptr;
  logic [PKT_W:0]   rem     [NCH];
  logic [PKT_W:0]   load    [NCH];
  logic [PKT_W:0]   src     [NCH];
  logic [PKT_W:0]   nxt_rem [NCH];
  logic [NCH-1:0]   req, grant;
  logic             any_req;
  logic             st_edge, en_edge;
  logic             launch, enter_run, strobe_now, finish_now, go_gap, abort_now;

  // In IDLE the arbiter looks at the incoming counts so a simultaneous
  // enable+start launch with zero delay can strobe without a latch cycle.
  always_comb begin
    st_edge = start & ~start_q;
    en_edge = enable & ~enable_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      load[i] = ch_mask[i] ? {packet_no[i*PKT_W +: PKT_W], 1'b0} : '0;
      src[i]  = (state == S_IDLE) ? load[i] : rem[i];
      req[i]  = (src[i] != '0);
    end
  end

  rr_arbiter_nch #(.NCH(NCH)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr),
    .any_req  (any_req)
  );

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      nxt_rem[i] = src[i] - {{PKT_W{1'b0}}, grant[i]};
    launch     = ((state == S_IDLE) && en_edge && st_edge) ||
                 ((state == S_ARMED) && (st_edge || start_pending));
    enter_run  = (launch && (EXTRA_DELAY == 0)) ||
                 ((state == S_DELAY) && (dly_cnt <= 8'd1));
    strobe_now = any_req && (enter_run ||
                 ((state == S_GAP) && (gap_cnt <= GAP_W'(1))) ||
                 ((state == S_READ) && (gap_cfg == '0)));
    finish_now = !any_req && (enter_run || (state == S_READ));
    go_gap     = (state == S_READ) && any_req && (gap_cfg != '0);
  end

`ifdef MEMFIFO_RE_ABORT_EN
  assign abort_now = abort && (state != S_IDLE) && (state != S_DONE);
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      start_q         <= 1'b0;
      enable_q        <= 1'b0;
      start_pending   <= 1'b0;
      dly_cnt         <= '0;
      gap_cnt         <= '0;
      ptr             <= '0;
      for (int unsigned i = 0; i < NCH; i++) rem[i] <= '0;
      memfifo_re      <= '0;
      last_memfifo_re <= 1'b0;
      busy            <= 1'b0;
    end else begin
      start_q         <= start;
      enable_q        <= enable;
      memfifo_re      <= '0;
      last_memfifo_re <= 1'b0;
      if (abort_now) begin
        state           <= S_DONE;
        last_memfifo_re <= 1'b1;
        busy            <= 1'b1;
        for (int unsigned i = 0; i < NCH; i++) rem[i] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (en_edge) begin
              for (int unsigned i = 0; i < NCH; i++) rem[i] <= src[i];
              if (st_edge) begin
                busy          <= 1'b1;
                start_pending <= 1'b0;
                state         <= S_DELAY;
                dly_cnt       <= DELAY_INIT;
              end else begin
                state <= S_ARMED;
              end
            end else if (st_edge) begin
              start_pending <= 1'b1;
            end
          end
          S_ARMED: begin
            if (launch) begin
              start_pending <= 1'b0;
              busy          <= 1'b1;
              state         <= S_DELAY;
              dly_cnt       <= DELAY_INIT;
            end
          end
          S_DELAY: dly_cnt <= dly_cnt - 8'd1;
          S_READ: begin
            if (go_gap) begin
              state   <= S_GAP;
              gap_cnt <= gap_cfg;
            end
          end
          S_GAP:   gap_cnt <= gap_cnt - GAP_W'(1);
          S_DONE: begin
            busy  <= 1'b0;
            ptr   <= '0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
        // Strobe/finish decisions override the per-state defaults above.
        if (strobe_now) begin
          state      <= S_READ;
          memfifo_re <= grant;
          ptr        <= next_ptr;
          for (int unsigned i = 0; i < NCH; i++) rem[i] <= nxt_rem[i];
        end else if (finish_now) begin
          state           <= S_DONE;
          last_memfifo_re <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memfifo_re_sequencer.sv
// Self-checking bench for memfifo_re_sequencer: directed vector table, corner sequences, random runs.
module tb_memfifo_re_sequencer;

  localparam int unsigned NCH   = 4;
  localparam int unsigned PKT_W = 16;
  localparam int unsigned ED    = 11;
  localparam int unsigned GAP_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 enable = 1'b0;
`ifdef MEMFIFO_RE_ABORT_EN
  logic                 abort = 1'b0;
`endif
  logic [NCH*PKT_W-1:0] packet_no = '0;
  logic [NCH-1:0]       ch_mask = '0;
  logic [GAP_W-1:0]     gap_cfg = '0;
  logic [NCH-1:0]       memfifo_re;
  logic                 last_memfifo_re;
  logic                 busy;

  always #5 clk = ~clk;

  memfifo_re_sequencer #(.NCH(NCH), .PKT_W(PKT_W), .EXTRA_DELAY(ED), .GAP_W(GAP_W)) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef MEMFIFO_RE_ABORT_EN
    .abort           (abort),
`endif
    .start           (start),
    .enable          (enable),
    .packet_no       (packet_no),
    .ch_mask         (ch_mask),
    .gap_cfg         (gap_cfg),
    .memfifo_re      (memfifo_re),
    .last_memfifo_re (last_memfifo_re),
    .busy            (busy)
  );

  int checks = 0;
  int failures = 0;

  int obs_ch[$], obs_t[$];
  int obs_last_t, obs_last_n, obs_busy_first, obs_busy_n, obs_multi;
  int exp_ch[$], exp_t[$];
  int exp_last;

  typedef struct {
    logic [63:0] pk;
    logic [3:0]  mask;
    logic [3:0]  gap;
    int          mode;
    string       order;
    int          first;
    int          period;
    int          last_t;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: start+enable together; 1: enable then start; 2: start 5 cycles before enable.
  // Cycle k counts from the cycle in which the launching start is sampled.
  task automatic run(input logic [63:0] pk, input logic [3:0] mask, input logic [3:0] gap,
                     input int mode, input int new_gap, input bit glitch,
                     input int rst_after, input int abort_after);
    int  k, nb;
    bit  done;
    obs_ch.delete(); obs_t.delete();
    obs_last_t = -1; obs_last_n = 0; obs_busy_first = -1; obs_busy_n = 0; obs_multi = 0;
    @(negedge clk);
    packet_no = pk; ch_mask = mask; gap_cfg = gap;
    case (mode)
      0: begin start = 1'b1; enable = 1'b1; end
      1: begin enable = 1'b1; @(negedge clk); enable = 1'b0; start = 1'b1; end
      default: begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1; @(negedge clk); enable = 1'b0;
      end
    endcase
    k = 0;
    done = 1'b0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
      nb = $countones(memfifo_re);
      if (nb > 1) obs_multi++;
      if (nb == 1)
        for (int c = 0; c < int'(NCH); c++)
          if (memfifo_re[c]) begin obs_ch.push_back(c); obs_t.push_back(k); end
      if (last_memfifo_re) begin obs_last_n++; if (obs_last_t < 0) obs_last_t = k; end
      if (busy) begin obs_busy_n++; if (obs_busy_first < 0) obs_busy_first = k; end
      if (k == 1) begin start = 1'b0; enable = 1'b0; end
      if (glitch && k == 4) begin start = 1'b1; enable = 1'b1; end
      if (glitch && k == 5) begin start = 1'b0; enable = 1'b0; end
      if (new_gap >= 0 && nb == 1 && obs_ch.size() == 1) gap_cfg = 4'(new_gap);
`ifdef MEMFIFO_RE_ABORT_EN
      if (abort_after > 0 && obs_ch.size() == abort_after && obs_t[$] + 3 == k) abort = 1'b1;
      else abort = 1'b0;
`endif
      if (rst_after > 0 && nb == 1 && obs_ch.size() == rst_after) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {memfifo_re, last_memfifo_re, busy}, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; enable = 1'b0;
        return;
      end
      if (obs_busy_first >= 0 && !busy) done = 1'b1;
    end
    if (!done) chk("run_timeout", 1, 0);
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, "_nstrobes"}, obs_ch.size(), exp_ch.size());
    n = (obs_ch.size() < exp_ch.size()) ? obs_ch.size() : exp_ch.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ch%0d", tag, i), obs_ch[i], exp_ch[i]);
      chk($sformatf("%s_t%0d", tag, i), obs_t[i], exp_t[i]);
    end
    chk({tag, "_last_t"}, obs_last_t, exp_last);
    chk({tag, "_last_n"}, obs_last_n, 1);
    chk({tag, "_busy_first"}, obs_busy_first, 1);
    chk({tag, "_busy_len"}, obs_busy_n, exp_last);
    chk({tag, "_onehot"}, obs_multi, 0);
  endtask

  task automatic exp_from_table(input vec_t v);
    exp_ch.delete(); exp_t.delete();
    for (int i = 0; i < v.order.len(); i++) begin
      exp_ch.push_back(int'(v.order[i]) - 48);
      exp_t.push_back(v.first + i * v.period);
    end
    exp_last = v.last_t;
  endtask

  // Reference: per-channel word pool, scan from the channel after the last one served.
  task automatic model(input logic [63:0] pk, input logic [3:0] mask, input int gap, input int new_gap);
    int w[4];
    int total, p, c, t, step;
    exp_ch.delete(); exp_t.delete();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = mask[i] ? 2 * int'(pk[i*16 +: 16]) : 0;
      total += w[i];
    end
    step = ((new_gap >= 0) ? new_gap : gap) + 1;
    p = 0;
    t = 1 + int'(ED);
    while (total > 0) begin
      c = p;
      while (w[c] == 0) c = (c + 1) % 4;
      exp_ch.push_back(c);
      exp_t.push_back(t);
      w[c]--; total--;
      p = (c + 1) % 4;
      t += step;
    end
    exp_last = (exp_t.size() > 0) ? exp_t[$] + 1 : 1 + int'(ED);
  endtask

  initial begin
    tbl[0] = '{pk: {16'd1, 16'd2, 16'd0, 16'd1}, mask: 4'b1111, gap: 4'd8, mode: 1,
               order: "02302322", first: 12, period: 9, last_t: 76};
    tbl[1] = '{pk: {16'd0, 16'd0, 16'd0, 16'd3}, mask: 4'b1111, gap: 4'd0, mode: 0,
               order: "000000", first: 12, period: 1, last_t: 18};
    tbl[2] = '{pk: 64'd0, mask: 4'b1111, gap: 4'd3, mode: 1,
               order: "", first: 12, period: 4, last_t: 12};
    tbl[3] = '{pk: {16'd1, 16'd1, 16'd1, 16'd1}, mask: 4'b0101, gap: 4'd1, mode: 2,
               order: "0202", first: 12, period: 2, last_t: 19};
    tbl[4] = '{pk: {16'd0, 16'd0, 16'd1, 16'd2}, mask: 4'b1111, gap: 4'd2, mode: 0,
               order: "010100", first: 12, period: 3, last_t: 28};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {memfifo_re, last_memfifo_re, busy}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].pk, tbl[i].mask, tbl[i].gap, tbl[i].mode, -1, 1'b0, -1, -1);
      exp_from_table(tbl[i]);
      verify($sformatf("vec%0d", i));
    end

    run(tbl[0].pk, tbl[0].mask, tbl[0].gap, 1, -1, 1'b0, 3, -1);
    chk("rst_mid_strobes_seen", obs_ch.size(), 3);
    run(tbl[0].pk, tbl[0].mask, tbl[0].gap, 1, -1, 1'b0, -1, -1);
    exp_from_table(tbl[0]);
    verify("post_rst");

    run({16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001, 4'd4, 0, 1, 1'b0, -1, -1);
    exp_ch = '{0, 0, 0, 0};
    exp_t  = '{12, 14, 16, 18};
    exp_last = 19;
    verify("gap_change");

`ifdef MEMFIFO_RE_ABORT_EN
    run(tbl[0].pk, tbl[0].mask, 4'd8, 1, -1, 1'b0, -1, 2);
    exp_ch = '{0, 2};
    exp_t  = '{12, 21};
    exp_last = 25;
    verify("abort");
`endif

    for (int r = 0; r < 16; r++) begin
      logic [63:0] pk;
      logic [3:0]  mask;
      int          gap, mode, ng;
      bit          gl;
      for (int c = 0; c < 4; c++) pk[c*16 +: 16] = 16'($urandom_range(0, 3));
      mask = 4'($urandom_range(0, 15));
      gap  = int'($urandom_range(0, 4));
      mode = int'($urandom_range(0, 2));
      ng   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      gl   = 1'($urandom_range(0, 1));
      run(pk, mask, 4'(gap), mode, ng, gl, -1, -1);
      model(pk, mask, gap, ng);
      verify($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
